umi_mem_tester: RTL



---
 rtl/umi_mem_tester.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/umi_mem_tester.sv
// umi_mem_tester: UMI host-side initiator that writes a pattern to NUM_WORDS words, reads it back and counts mismatches.
// Optional response timeout: define UMI_MEM_TESTER_TIMEOUT_EN (adds the `timeout` output).
module umi_mem_tester #(
  parameter int unsigned    DW        = 256,
  parameter int unsigned    AW        = 64,
  parameter int unsigned    CW        = 32,
  parameter int unsigned    NUM_WORDS = 16,
  parameter logic [AW-1:0]  BASE_ADDR = '0,
  parameter logic [AW-1:0]  SRC_ADDR  = AW'(64'h1000),
  parameter int unsigned    TIMEOUT   = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_count,
`ifdef UMI_MEM_TESTER_TIMEOUT_EN
  output logic          timeout,
`endif
  output logic          uhost_req_valid,
  output logic [CW-1:0] uhost_req_cmd,
  output logic [AW-1:0] uhost_req_dstaddr,
  output logic [AW-1:0] uhost_req_srcaddr,
  output logic [DW-1:0] uhost_req_data,
  input  logic          uhost_req_ready,
  input  logic          uhost_resp_valid,
  input  logic [CW-1:0] uhost_resp_cmd,
  input  logic [AW-1:0] uhost_resp_dstaddr,
  input  logic [AW-1:0] uhost_resp_srcaddr,
  input  logic [DW-1:0] uhost_resp_data,
  output logic          uhost_resp_ready
);

  localparam int unsigned   NLANES     = DW / 32;
  localparam logic [2:0]    SIZE       = 3'($clog2(DW / 8));
  localparam logic [AW-1:0] STRIDE     = AW'(DW / 8);
  localparam logic [15:0]   LAST       = 16'(NUM_WORDS - 1);
  localparam logic [4:0]    REQ_WRITE  = 5'h03;
  localparam logic [4:0]    REQ_READ   = 5'h01;
  localparam logic [4:0]    RESP_WRITE = 5'h04;
  localparam logic [4:0]    RESP_READ  = 5'h02;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

  state_t        state, state_nx;
  logic [15:0]   idx;
  logic [DW-1:0] pattern;
  logic          resp_fire;
  logic          tmo_hit;
  logic          idle_start;
  logic [1:0]    err_inc;
  logic [16:0]   err_sum;
  logic          unused_ok;

  assign unused_ok  = ^{uhost_resp_srcaddr, uhost_resp_cmd[CW-1:5]};
  // Derived from state rather than resp_ready to keep the next-state logic free of feedback.
  assign resp_fire  = uhost_resp_valid && (state == WR_RESP || state == RD_RESP);
  assign idle_start = (state == IDLE || state == DONE) && start;

  always_comb begin
    pattern = '0;
    for (int unsigned k = 0; k < NLANES; k++)
      pattern[k*32 +: 32] = {idx, k[7:0], 8'hA5};
  end

  always_comb begin
    err_inc = '0;
    if (resp_fire) begin
      err_inc = 2'(uhost_resp_cmd[4:0] != ((state == WR_RESP) ? RESP_WRITE : RESP_READ))
              + 2'(uhost_resp_dstaddr != SRC_ADDR);
      if (state == RD_RESP && uhost_resp_data != pattern) err_inc = err_inc + 2'd1;
    end else if (tmo_hit) begin
      err_inc = 2'd1;
    end
    err_sum = {1'b0, err_count} + 17'(err_inc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx          = state;
    busy              = 1'b0;
    done              = 1'b0;
    uhost_req_valid   = 1'b0;
    uhost_resp_ready  = 1'b0;
    uhost_req_cmd     = '0;
    uhost_req_dstaddr = '0;
    uhost_req_srcaddr = '0;
    uhost_req_data    = '0;
    case (state)
      IDLE: if (start) state_nx = WR_REQ;
      WR_REQ, RD_REQ: begin
        busy               = 1'b1;
        uhost_req_valid    = 1'b1;
        uhost_req_cmd[4:0] = (state == WR_REQ) ? REQ_WRITE : REQ_READ;
        uhost_req_cmd[7:5] = SIZE;
        uhost_req_dstaddr  = BASE_ADDR + AW'(idx) * STRIDE;
        uhost_req_srcaddr  = SRC_ADDR;
        if (state == WR_REQ) uhost_req_data = pattern;
        if (uhost_req_ready) state_nx = (state == WR_REQ) ? WR_RESP : RD_RESP;
      end
      WR_RESP, RD_RESP: begin
        busy             = 1'b1;
        uhost_resp_ready = 1'b1;
        if (resp_fire) begin
          if (idx != LAST) state_nx = (state == WR_RESP) ? WR_REQ : RD_REQ;
          else             state_nx = (state == WR_RESP) ? RD_REQ : DONE;
        end else if (tmo_hit) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nx = WR_REQ;
      end
      default: state_nx = IDLE;
    endcase
    pass = done && (err_count == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      err_count <= '0;
    end else if (idle_start) begin
      idx       <= '0;
      err_count <= '0;
    end else begin
      if (resp_fire) idx <= (idx == LAST) ? '0 : idx + 16'd1;
      if (resp_fire || tmo_hit) err_count <= err_sum[16] ? '1 : err_sum[15:0];
    end
  end

`ifdef UMI_MEM_TESTER_TIMEOUT_EN
  logic [31:0] wait_cnt;

  assign tmo_hit = (state == WR_RESP || state == RD_RESP) && !resp_fire
                   && (wait_cnt == 32'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      wait_cnt <= (state == WR_RESP || state == RD_RESP) ? wait_cnt + 32'd1 : '0;
      if (idle_start)   timeout <= 1'b0;
      else if (tmo_hit) timeout <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

endmodule
